// File: rtl/pc_sequencer_if.sv
// Bus between the next-PC sequencer and its surroundings: PC register,
// instruction memory and the decode stage that supplies flow control.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned RS_PTR_W = 3
);
  logic [WIDTH-1:0]  pc_cur;
  logic              imem_ack;
  logic              stall;
  logic              branch_taken;
  logic              jump;
  logic              call;
  logic              ret;
  logic              halt;
  logic [WIDTH-1:0]  target;
  logic [WIDTH-1:0]  pc_next;
  logic              pc_we;
  logic              imem_req;
  logic [RS_PTR_W:0] rs_count;
  logic              rs_overflow;
  logic              rs_underflow;
  logic              halted;

  modport master (
    input  pc_cur, imem_ack, stall, branch_taken, jump, call, ret, halt, target,
    output pc_next, pc_we, imem_req, rs_count, rs_overflow, rs_underflow, halted
  );

  modport slave (
    output pc_cur, imem_ack, stall, branch_taken, jump, call, ret, halt, target,
    input  pc_next, pc_we, imem_req, rs_count, rs_overflow, rs_underflow, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection and fetch sequencing with a return-address stack.
// One fetch request/acknowledge per instruction; flow decided in a single DECIDE cycle.
module pc_sequencer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned RS_PTR_W = 3
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.master bus
);
  localparam int unsigned CntW = RS_PTR_W + 1;
  localparam logic [CntW-1:0] RsFull = CntW'(RS_DEPTH);

  typedef enum logic [1:0] {StFetch, StDecide, StHalt} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    pc_next_q, pc_next_d;
  logic                pc_we_q, pc_we_d;
  logic [CntW-1:0]     rs_count_q, rs_count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [WIDTH-1:0]    rs_q [RS_DEPTH];
  logic                push;
  logic [WIDTH-1:0]    pc_inc;
  logic [RS_PTR_W-1:0] wr_idx, rd_idx;

  assign pc_inc = bus.pc_cur + WIDTH'(1);
  assign wr_idx = rs_count_q[RS_PTR_W-1:0];
  assign rd_idx = wr_idx - RS_PTR_W'(1);

  always_comb begin
    state_d    = state_q;
    pc_next_d  = pc_next_q;
    pc_we_d    = 1'b0;
    rs_count_d = rs_count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    push       = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (bus.imem_ack) state_d = StDecide;
      end
      StDecide: begin
        if (bus.halt) begin
          state_d = StHalt;
        end else if (!bus.stall) begin
          state_d   = StFetch;
          pc_we_d   = 1'b1;
          pc_next_d = pc_inc;
          // ret outranks call, so call+ret together is a plain return
          if (bus.ret) begin
            if (rs_count_q != '0) begin
              pc_next_d  = rs_q[rd_idx];
              rs_count_d = rs_count_q - CntW'(1);
            end else begin
              unf_d = 1'b1;
            end
          end else if (bus.call) begin
            pc_next_d = bus.target;
            if (rs_count_q != RsFull) begin
              push       = 1'b1;
              rs_count_d = rs_count_q + CntW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (bus.jump || bus.branch_taken) begin
            pc_next_d = bus.target;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_next_q  <= '0;
      pc_we_q    <= 1'b0;
      rs_count_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_next_q  <= pc_next_d;
      pc_we_q    <= pc_we_d;
      rs_count_q <= rs_count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) rs_q[wr_idx] <= pc_inc;
  end

  assign bus.pc_next      = pc_next_q;
  assign bus.pc_we        = pc_we_q;
  assign bus.imem_req     = (state_q == StFetch) && !reset;
  assign bus.rs_count     = rs_count_q;
  assign bus.rs_overflow  = ovf_q;
  assign bus.rs_underflow = unf_q;
  assign bus.halted       = (state_q == StHalt);
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a model return stack predicts each pc_we
// pulse into a scoreboard; a monitor pops and compares when the pulse appears.
module tb_pc_sequencer;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned PW = 3;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [PW:0]  cnt;
    logic         ovf;
    logic         unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(W), .RS_PTR_W(PW)) bus ();

  pc_sequencer #(.WIDTH(W), .RS_DEPTH(D), .RS_PTR_W(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t         sb_q[$];
  logic [W-1:0] m_rs[$];
  logic         m_ovf;
  logic         m_unf;
  int           n_assert = 0;
  int           n_fail   = 0;
  logic         prev_we  = 1'b0;
  exp_t         mon_e;
  exp_t         mon_got;

  // Monitor: every pc_we pulse must match the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (bus.pc_we === 1'b1) begin
      n_assert++;
      if (prev_we === 1'b1) begin
        n_fail++;
        $display("FAIL pc_we_double: pc_we=1 on consecutive cycles, required single-cycle pulse");
      end
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: pc_we=1 pc_next=%h with no predicted transfer",
                 bus.pc_next);
      end else begin
        mon_e   = sb_q.pop_front();
        mon_got = {bus.pc_next, bus.rs_count, bus.rs_overflow, bus.rs_underflow};
        if (mon_got !== mon_e) begin
          n_fail++;
          $display("FAIL sb_entry: got pc_next=%h rs_count=%0d ovf=%b unf=%b, required pc_next=%h rs_count=%0d ovf=%b unf=%b",
                   mon_got.pc, mon_got.cnt, mon_got.ovf, mon_got.unf,
                   mon_e.pc, mon_e.cnt, mon_e.ovf, mon_e.unf);
        end
      end
    end
    prev_we = bus.pc_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    bus.imem_ack     = 1'b0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.call         = 1'b0;
    bus.ret          = 1'b0;
    bus.halt         = 1'b0;
    bus.target       = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    m_rs.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    reset = 1'b0;
  endtask

  // One instruction: FETCH (ack after ack_wait cycles), DECIDE (stall_cyc stalled
  // cycles), then the pc_we cycle. Starts and ends at a negedge in FETCH.
  task automatic run_instr(input logic [W-1:0] pc, input logic [W-1:0] tgt,
                           input bit r, input bit c, input bit j, input bit b,
                           input int ack_wait, input int stall_cyc, output int req_cycles);
    exp_t         e;
    logic [W-1:0] inc;
    inc        = pc + 16'd1;
    req_cycles = 0;
    bus.pc_cur = pc;
    for (int i = 0; i <= ack_wait; i++) begin
      bus.imem_ack = (i == ack_wait);
      if (bus.imem_req === 1'b1) req_cycles++;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    n_assert++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL decide_req: imem_req=%b in DECIDE, required 0", bus.imem_req);
    end
    bus.ret = r; bus.call = c; bus.jump = j; bus.branch_taken = b; bus.target = tgt;
    bus.stall = (stall_cyc > 0);
    for (int i = 0; i < stall_cyc; i++) begin
      @(negedge clk);
      n_assert++;
      if (bus.pc_we !== 1'b0 || bus.imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: pc_we=%b imem_req=%b while stalled, required 0 0",
                 bus.pc_we, bus.imem_req);
      end
    end
    bus.stall = 1'b0;
    // Reference model of the flow decision.
    if (r) begin
      if (m_rs.size() > 0) e.pc = m_rs.pop_back();
      else begin e.pc = inc; m_unf = 1'b1; end
    end else if (c) begin
      e.pc = tgt;
      if (m_rs.size() < D) m_rs.push_back(inc);
      else m_ovf = 1'b1;
    end else if (j || b) begin
      e.pc = tgt;
    end else begin
      e.pc = inc;
    end
    e.cnt = (PW + 1)'(m_rs.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb_q.push_back(e);
    @(negedge clk);
    clear_inputs();
    n_assert++;
    if (bus.pc_we !== 1'b1 || bus.pc_next !== e.pc) begin
      n_fail++;
      $display("FAIL we_pulse: pc_we=%b pc_next=%h, required 1 %h", bus.pc_we, bus.pc_next,
               e.pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.pc_cur = '0;
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if ({bus.pc_next, bus.pc_we, bus.rs_count, bus.rs_overflow, bus.rs_underflow,
         bus.halted, bus.imem_req} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: pc_next=%h we=%b cnt=%0d ovf=%b unf=%b halted=%b req=%b, required all 0",
               bus.pc_next, bus.pc_we, bus.rs_count, bus.rs_overflow, bus.rs_underflow,
               bus.halted, bus.imem_req);
    end
    m_rs.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    reset = 1'b0;
    #1;
    n_assert++;
    if (bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_req: imem_req=%b, required 1", bus.imem_req);
    end
  endtask

  task automatic test_sequential();
    int req;
    run_instr(16'h0010, 16'h0000, 0, 0, 0, 0, 1, 0, req);
    n_assert++;
    if (req != 2) begin
      n_fail++;
      $display("FAIL seq_req_cycles: imem_req high %0d cycles, required 2", req);
    end
    run_instr(16'h0011, 16'h0000, 0, 0, 0, 0, 0, 0, req);
    n_assert++;
    if (req != 1) begin
      n_fail++;
      $display("FAIL min_period_req: imem_req high %0d cycles, required 1", req);
    end
    run_instr(16'h0012, 16'h0800, 0, 0, 0, 1, 0, 0, req);
    run_instr(16'h0800, 16'h0900, 0, 0, 1, 1, 2, 0, req);
  endtask

  task automatic test_call_ret();
    int req;
    run_instr(16'h0040, 16'h0200, 0, 1, 0, 0, 0, 0, req);
    run_instr(16'h0205, 16'h0000, 1, 0, 0, 0, 1, 0, req);
  endtask

  task automatic test_nested();
    int req;
    for (int i = 0; i < 9; i++)
      run_instr(16'(16'h1000 + i * 16), 16'(16'h2000 + i * 16), 0, 1, 0, 0, 0, 0, req);
    n_assert++;
    if (bus.rs_count !== 4'd8 || bus.rs_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL rs_saturate: rs_count=%0d ovf=%b, required 8 1", bus.rs_count,
               bus.rs_overflow);
    end
    for (int i = 0; i < 8; i++)
      run_instr(16'(16'h3000 + i), 16'h0000, 1, 0, 0, 0, 0, 0, req);
  endtask

  task automatic test_underflow();
    int req;
    do_reset();
    run_instr(16'h0100, 16'h0000, 1, 0, 0, 0, 0, 0, req);
    run_instr(16'h0101, 16'h0000, 0, 0, 0, 0, 0, 0, req);
    run_instr(16'h0102, 16'h0400, 0, 0, 1, 0, 1, 0, req);
    n_assert++;
    if (bus.rs_underflow !== 1'b1 || bus.rs_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_sticky: unf=%b ovf=%b, required 1 0", bus.rs_underflow,
               bus.rs_overflow);
    end
  endtask

  task automatic test_wrap();
    int req;
    run_instr(16'hFFFF, 16'h0000, 0, 0, 0, 0, 0, 0, req);
    run_instr(16'hFFFF, 16'h0300, 0, 1, 0, 0, 0, 0, req);
    run_instr(16'h0305, 16'h0000, 1, 0, 0, 0, 0, 0, req);
  endtask

  task automatic test_stall();
    int req;
    run_instr(16'h0500, 16'h1234, 0, 0, 1, 0, 0, 5, req);
  endtask

  task automatic test_call_ret_same();
    int req;
    run_instr(16'h0600, 16'h0700, 0, 1, 0, 0, 0, 0, req);
    run_instr(16'h0705, 16'h0900, 1, 1, 1, 1, 0, 0, req);
  endtask

  task automatic test_halt_reset();
    int req;
    bus.pc_cur   = 16'h0800;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.halt     = 1'b1;
    bus.jump     = 1'b1;
    bus.target   = 16'h1111;
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      n_assert++;
      if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc_we !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_hold: halted=%b imem_req=%b pc_we=%b, required 1 0 0",
                 bus.halted, bus.imem_req, bus.pc_we);
      end
      bus.imem_ack = 1'(i % 2);
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({bus.pc_next, bus.pc_we, bus.rs_count, bus.rs_overflow, bus.rs_underflow,
         bus.halted, bus.imem_req} !== '0) begin
      n_fail++;
      $display("FAIL halt_reset_state: pc_next=%h we=%b cnt=%0d ovf=%b unf=%b halted=%b req=%b, required all 0",
               bus.pc_next, bus.pc_we, bus.rs_count, bus.rs_overflow, bus.rs_underflow,
               bus.halted, bus.imem_req);
    end
    m_rs.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    reset = 1'b0;
    #1;
    n_assert++;
    if (bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_restart_req: imem_req=%b, required 1", bus.imem_req);
    end
    run_instr(16'h0020, 16'h0000, 0, 0, 0, 0, 0, 0, req);
  endtask

  initial begin
    reset      = 1'b1;
    bus.pc_cur = '0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_call_ret();
    test_nested();
    test_underflow();
    test_wrap();
    test_stall();
    test_call_ret_same();
    test_halt_reset();
    repeat (3) @(negedge clk);
    n_assert++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d predicted transfers never seen, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC and fetch-control stage directly upstream of the 16-bit PC register.
- Drives the PC register's data input and enable.
- Sequences one instruction-memory request/acknowledge per instruction.
- Resolves sequential, branch, jump, call and return flow, with an internal return-address stack (RS).

Parameters:
WIDTH, 16, address width of PC and all targets
RS_DEPTH, 8, return-stack entries (power of two)
RS_PTR_W, 3, log2(RS_DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
pc_cur  input  WIDTH  current PC (PC register output)
imem_ack  input  1  instruction memory has returned the word for pc_cur
stall  input  1  downstream not ready; hold in DECIDE
branch_taken  input  1  conditional branch resolved taken
jump  input  1  unconditional jump
call  input  1  subroutine call (push return address)
ret  input  1  subroutine return (pop)
halt  input  1  stop fetching
target  input  WIDTH  branch/jump/call destination
pc_next  output  WIDTH  PC register din
pc_we  output  1  PC register enable, one-cycle pulse
imem_req  output  1  fetch request for pc_cur
rs_count  output  RS_PTR_W+1  valid RS entries, 0..RS_DEPTH
rs_overflow  output  1  sticky: call attempted with RS full
rs_underflow  output  1  sticky: ret attempted with RS empty
halted  output  1  in HALT state

Behaviour:
- Reset (sampled on clk edge while reset=1):
  - State FETCH.
  - pc_next=0, pc_we=0, imem_req=0, rs_count=0, rs_overflow=0, rs_underflow=0, halted=0.
  - RS contents don't-care.
  - Reset overrides everything, including mid-fetch and HALT.
- Outputs are registered; imem_req is combinational from state (1 in FETCH when reset=0).
- FETCH:
  - imem_req=1.
  - imem_ack=1 → DECIDE next cycle; else stay.
  - Control inputs are ignored in FETCH.
- DECIDE (control inputs valid only here):
  - halt=1 (highest priority) → HALT. No pc_we, no RS change.
  - Else if stall=1: remain in DECIDE. pc_we=0, RS unchanged.
  - Else select pc_next, pulse pc_we=1 on the following cycle, go to FETCH. Priority ret > call > jump > branch_taken > sequential:
    - ret, rs_count>0: pc_next=RS[top]; rs_count-1.
    - ret, rs_count=0: pc_next=pc_cur+1; rs_underflow←1.
    - call, rs_count<RS_DEPTH: push pc_cur+1; pc_next=target; rs_count+1.
    - call, rs_count=RS_DEPTH: no push; pc_next=target; rs_overflow←1.
    - jump or branch_taken: pc_next=target.
    - none: pc_next=pc_cur+1.
- Arithmetic: pc_cur+1 is modulo 2^WIDTH (0xFFFF→0x0000), including the pushed return address.
- Timing: the pc_we pulse lands in the first FETCH cycle. The PC register captures on that edge, so the next request uses the updated pc_cur one cycle later. pc_we is never high for two consecutive cycles.
- Minimum instruction period: 3 cycles (FETCH with immediate ack, DECIDE, FETCH).
- pc_next holds its last value when pc_we=0.
- HALT: halted=1, imem_req=0, pc_we=0. Exit only via reset.
- Sticky flags clear only on reset.
- RS is LIFO:
  - Push writes at index rs_count.
  - Pop reads index rs_count-1.
  - Simultaneous call+ret in one DECIDE resolves as ret only.

Test Plan:
- Reset, then imem_ack on the 2nd FETCH cycle, no control, pc_cur=0x0010 → imem_req high 2 cycles; pc_we pulse with pc_next=0x0011; period 4 cycles.
- call target=0x0200 at pc_cur=0x0040, then ret at pc_cur=0x0205 → pc_next=0x0200, rs_count 0→1; then pc_next=0x0041, rs_count 1→0.
- 9 nested calls (RS_DEPTH=8) → rs_count saturates at 8, rs_overflow=1 after 9th, pc_next=target each time; 8 rets return addresses in reverse order.
- ret with RS empty at pc_cur=0x0100 → pc_next=0x0101, rs_underflow=1 and stays 1 through later normal instructions.
- pc_cur=0xFFFF sequential → pc_next=0x0000; call at 0xFFFF pushes 0x0000.
- stall held 5 cycles in DECIDE with jump target=0x1234 → no pc_we during stall, single pc_we with 0x1234 after release.
- halt in DECIDE → halted=1, imem_req=0 indefinitely; reset asserted mid-HALT → all outputs return to reset values and fetch restarts.
